// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin, burst-bounded two-port arbiter in front of a
//            single-port word-addressed data memory, with registered reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int MEM_WORDS = 512,
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);
    localparam logic [3:0]  c_burst_max = 4'(BURST_MAX);

    logic        r_last_gnt;
    logic        r_owner;
    logic [3:0]  r_burst_cnt;
    logic        r_rvalid0, r_rvalid1;
    logic        r_err0, r_err1;
    logic [31:0] r_rdata0, r_rdata1;

    logic        w_any;
    logic        w_sel;
    logic        w_we;
    logic        w_err;
    logic        w_rd_ok;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    // Reset masks every grant so nothing reaches the memory while it is held.
    always_comb begin
        w_any = 1'b0;
        w_sel = 1'b0;
        if (reset) begin
            w_any = 1'b0;
        end else if (m0_req && m1_req) begin
            w_any = 1'b1;
            w_sel = (r_burst_cnt < c_burst_max) ? r_owner : ~r_last_gnt;
        end else if (m0_req) begin
            w_any = 1'b1;
        end else if (m1_req) begin
            w_any = 1'b1;
            w_sel = 1'b1;
        end
    end

    assign w_addr  = w_sel ? m1_addr  : m0_addr;
    assign w_wdata = w_sel ? m1_wdata : m0_wdata;
    assign w_we    = w_sel ? m1_we    : m0_we;
    assign w_err   = w_any && ((w_addr[1:0] != 2'b00) || (w_addr[31:2] >= c_mem_words));
    assign w_rd_ok = w_any && !w_we && !w_err;

    assign m0_gnt   = w_any && !w_sel;
    assign m1_gnt   = w_any && w_sel;
    assign mem_addr = w_any ? {2'b00, w_addr[31:2]} : 32'd0;
    assign mem_wd   = w_any ? w_wdata : 32'd0;
    assign mem_we   = w_any && w_we && !w_err;

    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign m0_err    = r_err0;
    assign m1_err    = r_err1;
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt  <= 1'b1;
            r_owner     <= 1'b0;
            r_burst_cnt <= 4'd0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rdata0    <= 32'd0;
            r_rdata1    <= 32'd0;
        end else begin
            r_rvalid0 <= w_rd_ok && !w_sel;
            r_rvalid1 <= w_rd_ok && w_sel;
            r_err0    <= w_err && !w_sel;
            r_err1    <= w_err && w_sel;
            if (w_rd_ok && !w_sel) r_rdata0 <= mem_rd;
            if (w_rd_ok && w_sel)  r_rdata1 <= mem_rd;

            // Burst counter saturates so a lone requester is never throttled.
            if (!w_any) begin
                r_burst_cnt <= 4'd0;
            end else if (w_sel == r_last_gnt) begin
                if (r_burst_cnt != 4'hF) r_burst_cnt <= r_burst_cnt + 4'd1;
            end else begin
                r_burst_cnt <= 4'd1;
                r_last_gnt  <= w_sel;
                r_owner     <= w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed vector table plus hand-written sequences for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int c_burst = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wd, mem_rd;

    logic [31:0] mem [0:511];

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.MEM_WORDS(512), .BURST_MAX(c_burst)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_err(m0_err), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr[8:0]] <= mem_wd;
    assign mem_rd = mem[mem_addr[8:0]];

    // flags = {m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid, m0_err, m1_err}
    typedef struct {
        logic        r0;
        logic        w0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [6:0]  flags;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [134:0] snap();
        return {m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid, m0_err, m1_err,
                mem_addr, mem_wd, m0_rdata, m1_rdata};
    endfunction

    task automatic check(input string name, input logic [134:0] act, input logic [134:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        vecs[0]  = '{1'b1, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0,   32'h0, 7'b1010000, 32'h4,   32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 7'b1000000, 32'h4,   32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 7'b0001000, 32'h0,   32'h0,        32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h802, 32'h0, 7'b0100000, 32'h200, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h800, 32'h0, 7'b0100001, 32'h200, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'h40,   32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,   32'h0, 7'b1010001, 32'h10,  32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 32'h20,   32'h12345678, 1'b1, 1'b0, 32'h20,  32'h0, 7'b1010000, 32'h8,   32'h12345678, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h20,  32'h0, 7'b0100000, 32'h8,   32'h0,        32'hDEADBEEF, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 7'b0000100, 32'h0,   32'h0,        32'hDEADBEEF, 32'h12345678};
        vecs[9]  = '{1'b1, 1'b0, 32'h40,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 7'b1000000, 32'h10,  32'h0,        32'hDEADBEEF, 32'h12345678};
        vecs[10] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 7'b0001000, 32'h0,   32'h0,        32'hA5A5A5A5, 32'h12345678};
        vecs[11] = '{1'b1, 1'b1, 32'h1000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,   32'h0, 7'b1000000, 32'h400, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h12345678};
        vecs[12] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 7'b0000010, 32'h0,   32'h0,        32'hA5A5A5A5, 32'h12345678};

        // Reset state, with a request present to confirm grants are masked.
        m0_req = 1'b1;
        @(negedge clk);
        check("reset_state", snap(), 135'd0);
        m0_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d", i), snap(),
                  {vecs[i].flags, vecs[i].maddr, vecs[i].mwd, vecs[i].rd0, vecs[i].rd1});
        end

        // Contention from a fresh reset: m0 x4, m1 x4, m0 x4.
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int c = 0; c < 12; c++) begin
            logic [1:0] exp_g;
            exp_g = ((c / 4) % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            check($sformatf("rr_cycle%0d", c), {133'd0, m0_gnt, m1_gnt}, {133'd0, exp_g});
            @(negedge clk);
        end

        // Reset in the cycle after a granted read drops the pending response.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("pre_reset_gnt", {133'd0, m0_gnt, m1_gnt}, {133'd0, 2'b10});
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("reset_drop", snap(), 135'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
        #1;
        check("restart_m0_prio", {133'd0, m0_gnt, m1_gnt}, {133'd0, 2'b10});

        // Lone requester for 10 cycles, then m1 joins and must get in quickly.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("solo_cycle%0d", c), {133'd0, m0_gnt, m1_gnt}, {133'd0, 2'b10});
            @(posedge clk); #1;
        end
        m1_req = 1'b1; m1_addr = 32'h14;
        waited = 0;
        @(negedge clk);
        while (!m1_gnt && waited < c_burst + 2) begin
            waited++;
            @(negedge clk);
        end
        check("m1_wait_bound", {103'd0, 32'(waited < c_burst)}, {103'd0, 32'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port word-addressed data memory. It shares the memory between requester 0 (core load/store path) and requester 1 (debug/DMA loader) using round-robin arbitration with a bounded burst. It converts byte addresses to word indices and rejects misaligned or out-of-range accesses. Read data returns as a registered response one cycle after grant.

## Interface
- MEM_WORDS, 512: memory depth in 32-bit words; valid word index is 0..MEM_WORDS-1.
- BURST_MAX, 4: maximum consecutive grants to one requester while the other is waiting; range 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- m0_req, m1_req  in  1  access request; held with its fields until granted.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_gnt, m1_gnt  out  1  combinational grant; the access is performed this cycle.
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse; rdata is valid.
- m0_rdata, m1_rdata  out  32  registered read data; holds its value between pulses.
- m0_err, m1_err  out  1  one-cycle pulse; the granted access was rejected.
- mem_addr  out  32  word index to memory, {2'b0, addr[31:2]} of the winner; 0 when idle.
- mem_wd  out  32  write data of the winner; 0 when idle.
- mem_we  out  1  memory write strobe; the write commits at the next rising edge.
- mem_rd  in  32  combinational memory read data.

## Operation
- State: last_gnt (1 bit, reset 1), owner (1 bit, reset 0), burst_cnt (4 bits, reset 0), response registers.
- Arbitration each cycle:
  - Only one requester asserting req: it is granted.
  - Both asserting: the current owner keeps the grant while burst_cnt < BURST_MAX. Otherwise the grant goes to the requester other than last_gnt.
- Grant bookkeeping: a grant to the same requester as last_gnt increments burst_cnt (saturating at 15). A grant to the other requester sets burst_cnt = 1 and updates last_gnt and owner.
- Idle cycle (no req): burst_cnt resets to 0; last_gnt is kept.
- Error check on the winner: misaligned when addr[1:0] != 0; out of range when addr[31:2] >= MEM_WORDS.
  - On error: mem_we is forced 0, no rvalid, and err pulses next cycle. rdata is unchanged.
- Granted valid write: mem_we = 1. No rvalid and no err.
- Granted valid read: mem_rd is captured into the winner's rdata at the edge, and rvalid pulses next cycle.
- The loser's gnt is 0. The loser must hold req and all fields unchanged; the block does not queue requests.

## Timing
- Reset values: gnt 0/0, rvalid 0/0, err 0/0, rdata 0/0, mem_we 0, mem_addr 0, mem_wd 0, last_gnt 1, burst_cnt 0.
- While reset is high, gnt and mem_we are forced 0.
- Reset asserted mid-operation: any pending rvalid/err for the next cycle is dropped, and rdata returns to 0.
- Grant latency: 0 cycles when uncontested. Read data latency: 1 cycle (grant at edge N, rvalid high in cycle N+1).
- Back-to-back grants to one requester are allowed every cycle. Each response pulse maps to exactly one grant, in order.
- Read-after-write to the same address on consecutive cycles returns the new data, because the memory write commits at the edge between the two cycles.
- Worst-case wait for a contending requester is BURST_MAX cycles.

## Test plan
- After reset, m0 writes 0xDEADBEEF to byte addr 0x10, then reads addr 0x10 -> mem_addr = 4, mem_we = 1 in cycle 1; m0_rvalid = 1 with rdata = 0xDEADBEEF in cycle 3.
- m0 and m1 both request reads continuously, BURST_MAX = 4 -> first grant goes to m0 (last_gnt reset 1); grant pattern m0×4, m1×4, m0×4; no cycle has both gnt high.
- m1 reads addr 0x802 (misaligned), then m1 reads addr 0x800 (index 512, out of range) -> m1_err pulses on both; mem_we stays 0; m1_rdata is unchanged.
- m0 writes 0x12345678 to 0x20 while m1 requests a read of 0x20 -> m0 granted first; m1 granted next cycle and receives 0x12345678.
- Assert reset in the cycle after a granted read -> m0_rvalid stays 0, rdata = 0, and the arbiter restarts with m0 priority.
- m0 requests alone for 10 cycles -> granted every cycle; burst_cnt saturates without blocking; m1 arriving later is granted within BURST_MAX cycles.
